current_source_ctrl: RTL
========================

# current_source_ctrl

Synchronous controller for the current-source unit array (16+1 thermometer cells, 6+1 binary cells). It sequences power-up through `pdb` and waits for settling. It then accepts 10-bit DAC codes over a valid/ready handshake and decodes them into per-cell enables, with redundant-cell repair. It also runs the analog-testbus scan over `atb_ena`, and sits between the digital calibration/configuration logic and the analog array.

## Interface
- `SETTLE_CYCLES`, default 64: cycles from `pdb` rise to first code acceptance (≥2).
- `TEST_CYCLES`, default 16: cycles each `atb_ena` setting is held during a scan (≥1).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `pwr_req` in 1: level request to power the array.
- `ref_ok` in 1: reference current and supplies within bounds.
- `code_valid` in 1, `code_ready` out 1, `code` in 10: DAC code handshake. `code[9:6]` is the thermometer count N (0..15); `code[5:0]` is the binary part.
- `repair_en` in 1, `repair_idx` in 4: thermometer unit `repair_idx` is replaced by unit 16.
- `lsb_repair` in 1: binary cell 0 is replaced by the redundant LSB cell.
- `atb_start` in 1: single-cycle pulse that requests a testbus scan.
- `pdb` out 1: array power-down negate.
- `atb_ena` out 2: testbus select.
- `them_en` out 17: thermometer cell enables; bit 16 is the redundant cell.
- `bin_en` out 7: binary enables; bits 5..0 are the weights, bit 6 is the redundant LSB.
- `active` out 1: array powered and settled.
- `fault` out 1: reference lost while powered.
- `atb_done` out 1: single-cycle pulse at scan end.

## Operation
- **States:** OFF, SETTLE, ACTIVE, ATB, FAULT.
- **OFF**
  - `pdb`=0; all enables 0.
  - `pwr_req`&&`ref_ok` → SETTLE; `pdb`=1 next cycle; counter loads SETTLE_CYCLES-1.
- **SETTLE**
  - Counter decrements each cycle.
  - Counter reaches 0 → ACTIVE.
  - Enables stay 0.
- **ACTIVE**
  - `code_ready`=1 and `active`=1.
  - Handshake (`code_valid`&&`code_ready`) registers the code.
  - Binary decode: `bin_en[5:0]`=`code[5:0]`.
  - If `lsb_repair`: `bin_en[6]`=`code[0]` and `bin_en[0]`=0.
- **Thermometer decode**
  - Exactly N of units 0..15 are enabled (contiguous set, see Configuration).
  - If `repair_en` and unit `repair_idx` is in the set: that unit is forced to 0 and `them_en[16]`=1.
  - The enabled-cell count stays N.
  - `repair_en`, `repair_idx` and `lsb_repair` are sampled only at handshake.
- **ATB**
  - Entered from ACTIVE on `atb_start`.
  - `code_ready`=0; current enables are held.
  - `atb_ena` steps 01 → 10 → 11, each held TEST_CYCLES, then returns to 00.
  - `atb_done` pulses on the return; next state is ACTIVE.
  - `atb_start` outside ACTIVE is ignored.
- **Priority, applied every cycle in non-OFF states**
  1. `ref_ok`=0 → FAULT.
  2. Else `pwr_req`=0 → OFF.
  3. Else normal transitions.
- **FAULT**
  - `pdb`=0, all enables 0, `atb_ena`=00, `fault`=1.
  - Leaves to OFF only when `pwr_req`=0; `fault` clears on that transition.
- **Simultaneous events:** `code_valid` and `atb_start` in the same ACTIVE cycle means the code is accepted and ATB is entered.

## Timing
- **Reset:** state OFF; `pdb`=0, `code_ready`=0, `atb_ena`=00, `them_en`=0, `bin_en`=0, `active`=0, `fault`=0, `atb_done`=0; DEM pointer 0.
- **All outputs are registered.**
- **Code latency:** handshake at cycle t → enables valid at t+1.
- **Power-up:** request sampled at t → `pdb`=1 at t+1 → `active`=1 and `code_ready`=1 at t+1+SETTLE_CYCLES.
- **Power-down/fault:** detected at t → `pdb`=0, enables 0 and `code_ready`=0 at t+1.
- **Mid-operation aborts:**
  - A fault or power-down during SETTLE or ATB aborts it immediately.
  - An ATB abort drives `atb_ena`=00 and does not pulse `atb_done`.
- **Scan length:** `atb_start` at t → `atb_ena`=01 at t+1 → `atb_ena`=00 and `atb_done`=1 at t+1+3·TEST_CYCLES.

## Configuration
- **Macro:** `CSU_DEM_EN`.
- **Defined:** dynamic element matching.
  - Units ptr..ptr+N-1 (mod 16) are enabled.
  - After each handshake, ptr ← (ptr+N) mod 16, wrapping past 15.
  - ptr resets to 0 on `rst` and on entry to OFF.
- **Undefined:** units 0..N-1 are enabled; no pointer register exists.

## Structure
- **Package `csu_ctrl_pkg`:**
  - state enum;
  - `atb_ena` encoding constants ATB_OFF=00, ATB_VDD18=01, ATB_VDD08=10, ATB_IREF=11;
  - THEM_UNITS=16, BIN_BITS=6.
- **Sub-module `csu_code_decoder`:** combinational mapping (code, repair inputs, pointer) → `them_en`/`bin_en`. The FSM, counters and output registers live in the top.

## Test plan
- **Reset, then `pwr_req`=1, `ref_ok`=1 at cycle 0:** `pdb`=1 at cycle 1; `active`=1 and `code_ready`=1 at cycle 65.
- **ACTIVE, code 0x2C5 (N=11, bin 0x05):**
  - without DEM, `them_en`=0x007FF and `bin_en`=0x05 next cycle;
  - with `lsb_repair`=1, `bin_en`=0x44.
- **`repair_en`=1, `repair_idx`=3, code N=5, no DEM:** `them_en`=0x10017 (units 0,1,2,4 plus bit 16).
- **`CSU_DEM_EN`, codes N=10 then N=10:** `them_en`=0x003FF then 0x0FC0F (units 10..15, 0..3); ptr=4.
- **`atb_start` in ACTIVE, TEST_CYCLES=16:**
  - `atb_ena` shows 01, 10, 11 for 16 cycles each; `code_ready`=0 throughout;
  - `atb_done` pulses at cycle 49 after the start.
- **Faults and power-down:**
  - `ref_ok`=0 mid-scan: next cycle FAULT, `pdb`=0, `atb_ena`=00, `fault`=1, no `atb_done`.
  - `pwr_req`=0 from FAULT → OFF, `fault`=0.
  - `pwr_req` drop during SETTLE → OFF, `active` never asserts.

Source files
------------

// File: rtl/csu_ctrl_pkg.sv
// Shared types and constants for the current-source array controller.
package csu_ctrl_pkg;

    typedef enum logic [2:0] {
        StOff,
        StSettle,
        StActive,
        StAtb,
        StFault
    } csu_state_e;

    localparam logic [1:0] ATB_OFF   = 2'b00;
    localparam logic [1:0] ATB_VDD18 = 2'b01;
    localparam logic [1:0] ATB_VDD08 = 2'b10;
    localparam logic [1:0] ATB_IREF  = 2'b11;

    localparam int unsigned THEM_UNITS = 16;
    localparam int unsigned BIN_BITS   = 6;

endpackage

// File: rtl/csu_code_decoder.sv
// Combinational DAC-code to cell-enable mapping with redundant-cell repair.
// The pointer selects the first thermometer unit; a constant 0 gives units 0..N-1.
module csu_code_decoder
    import csu_ctrl_pkg::*;
(
    input  logic [9:0]          code,
    input  logic                repair_en,
    input  logic [3:0]          repair_idx,
    input  logic                lsb_repair,
    input  logic [3:0]          ptr,
    output logic [THEM_UNITS:0] them_en,
    output logic [BIN_BITS:0]   bin_en
);

    logic [3:0] count;
    logic [3:0] offset;

    always_comb begin
        count   = code[9:6];
        offset  = '0;
        them_en = '0;
        // Unit i is on when its distance from the pointer (mod 16) is below N.
        for (int i = 0; i < THEM_UNITS; i++) begin
            offset     = 4'(i) - ptr;
            them_en[i] = (offset < count);
        end
        if (repair_en && them_en[repair_idx]) begin
            them_en[repair_idx] = 1'b0;
            them_en[THEM_UNITS] = 1'b1;
        end

        bin_en = {1'b0, code[BIN_BITS-1:0]};
        if (lsb_repair) begin
            bin_en[BIN_BITS] = code[0];
            bin_en[0]        = 1'b0;
        end
    end

endmodule

// File: rtl/current_source_ctrl.sv
// Power sequencing, code handshake and testbus scan for the current-source array.
// Define CSU_DEM_EN to rotate thermometer units with a dynamic-element-matching pointer.
module current_source_ctrl
    import csu_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned TEST_CYCLES   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwr_req,
    input  logic                ref_ok,
    input  logic                code_valid,
    output logic                code_ready,
    input  logic [9:0]          code,
    input  logic                repair_en,
    input  logic [3:0]          repair_idx,
    input  logic                lsb_repair,
    input  logic                atb_start,
    output logic                pdb,
    output logic [1:0]          atb_ena,
    output logic [THEM_UNITS:0] them_en,
    output logic [BIN_BITS:0]   bin_en,
    output logic                active,
    output logic                fault,
    output logic                atb_done
);

    localparam int unsigned CntMax = (SETTLE_CYCLES > TEST_CYCLES) ? SETTLE_CYCLES : TEST_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax);

    csu_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [1:0]           atb_q, atb_d;
    logic [THEM_UNITS:0]  them_q, them_d, dec_them;
    logic [BIN_BITS:0]    bin_q, bin_d, dec_bin;
    logic                 pdb_q, ready_q, active_q, fault_q, done_q, done_d;
    logic                 accept;
    logic [3:0]           dem_ptr;

    // A code is only taken when the cycle is not pre-empted by a fault or power-down.
    assign accept = (state_q == StActive) && code_valid && ref_ok && pwr_req;

`ifdef CSU_DEM_EN
    logic [3:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_d == StOff) begin
            ptr_d = '0;
        end else if (accept) begin
            ptr_d = ptr_q + code[9:6];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign dem_ptr = ptr_q;
`else
    assign dem_ptr = '0;
`endif

    csu_code_decoder u_decoder (
        .code       (code),
        .repair_en  (repair_en),
        .repair_idx (repair_idx),
        .lsb_repair (lsb_repair),
        .ptr        (dem_ptr),
        .them_en    (dec_them),
        .bin_en     (dec_bin)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        atb_d   = atb_q;
        them_d  = them_q;
        bin_d   = bin_q;
        done_d  = 1'b0;

        unique case (state_q)
            StOff: begin
                if (pwr_req && ref_ok) begin
                    state_d = StSettle;
                    cnt_d   = CntW'(SETTLE_CYCLES - 1);
                end
            end
            StFault: begin
                if (!pwr_req) begin
                    state_d = StOff;
                end
            end
            default: begin
                if (!ref_ok) begin
                    state_d = StFault;
                end else if (!pwr_req) begin
                    state_d = StOff;
                end else begin
                    unique case (state_q)
                        StSettle: begin
                            if (cnt_q == '0) begin
                                state_d = StActive;
                            end else begin
                                cnt_d = cnt_q - CntW'(1);
                            end
                        end
                        StActive: begin
                            if (accept) begin
                                them_d = dec_them;
                                bin_d  = dec_bin;
                            end
                            if (atb_start) begin
                                state_d = StAtb;
                                atb_d   = ATB_VDD18;
                                cnt_d   = CntW'(TEST_CYCLES - 1);
                            end
                        end
                        default: begin
                            if (cnt_q != '0) begin
                                cnt_d = cnt_q - CntW'(1);
                            end else if (atb_q == ATB_IREF) begin
                                state_d = StActive;
                                atb_d   = ATB_OFF;
                                done_d  = 1'b1;
                            end else begin
                                atb_d = atb_q + 2'd1;
                                cnt_d = CntW'(TEST_CYCLES - 1);
                            end
                        end
                    endcase
                end
            end
        endcase

        if (state_d == StOff || state_d == StFault) begin
            them_d = '0;
            bin_d  = '0;
            atb_d  = ATB_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StOff;
            cnt_q    <= '0;
            atb_q    <= ATB_OFF;
            them_q   <= '0;
            bin_q    <= '0;
            pdb_q    <= 1'b0;
            ready_q  <= 1'b0;
            active_q <= 1'b0;
            fault_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            atb_q    <= atb_d;
            them_q   <= them_d;
            bin_q    <= bin_d;
            pdb_q    <= (state_d != StOff) && (state_d != StFault);
            ready_q  <= (state_d == StActive);
            active_q <= (state_d == StActive) || (state_d == StAtb);
            fault_q  <= (state_d == StFault);
            done_q   <= done_d;
        end
    end

    assign code_ready = ready_q;
    assign pdb        = pdb_q;
    assign atb_ena    = atb_q;
    assign them_en    = them_q;
    assign bin_en     = bin_q;
    assign active     = active_q;
    assign fault      = fault_q;
    assign atb_done   = done_q;

endmodule
